// File: rtl/gsm_burst_serializer_if.sv
// Byte-in / symbol-out handshake bundle between a burst source, the serializer
// and the GMSK modulator that paces it.
interface gsm_burst_serializer_if;
    logic       burst_start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       next_symbol_strobe;
    logic       current_symbol;
    logic       burst_active;
    logic       burst_done;
    logic       underrun;

    modport master (
        output burst_start, data_in, data_valid, next_symbol_strobe,
        input  data_ready, current_symbol, burst_active, burst_done, underrun
    );

    modport slave (
        input  burst_start, data_in, data_valid, next_symbol_strobe,
        output data_ready, current_symbol, burst_active, burst_done, underrun
    );
endinterface

// File: rtl/gsm_burst_serializer.sv
// Assembles one GSM normal burst (tail, payload, tail, guard) from a byte stream and
// emits one (optionally differentially encoded) bit per modulator strobe.
module gsm_burst_serializer #(
    parameter int TAIL_BITS    = 3,
    parameter int PAYLOAD_BITS = 142,
    parameter int GUARD_BITS   = 8,
    parameter bit DIFF_ENCODE  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    gsm_burst_serializer_if.slave   bus
);

    localparam int CNT_W      = $clog2(PAYLOAD_BITS + 1);
    localparam int NUM_BYTES  = (PAYLOAD_BITS + 7) / 8;
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        TAIL,
        GUARD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             shift_q;
    logic [3:0]             bit_cnt_q;
    logic [BYTE_CNT_W-1:0]  bytes_q;
    logic                   prev_q;
    logic                   pending_q;
    logic                   symbol_q;
    logic                   done_q;
    logic                   underrun_q;

    logic                   sym_b;
    logic                   start_burst;
    logic                   done_d;
    logic                   start_req;
    logic                   payload_strobe;
    logic                   starve;
    logic                   ready;
    logic                   accept;

    assign start_req      = bus.burst_start | pending_q;
    assign payload_strobe = (state_q == PAYLOAD) & bus.next_symbol_strobe;
    assign starve         = payload_strobe & (bit_cnt_q == 4'd0);

    // A byte may be taken when the buffer is empty or is about to be emptied by this strobe.
    assign ready  = ((state_q == HEAD) || (state_q == PAYLOAD))
                  & ((bit_cnt_q == 4'd0) | ((bit_cnt_q == 4'd1) & payload_strobe))
                  & (bytes_q < BYTE_CNT_W'(NUM_BYTES));
    assign accept = bus.data_valid & ready;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sym_b       = 1'b0;
        start_burst = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d     = HEAD;
                    cnt_d       = '0;
                    start_burst = 1'b1;
                end
            end
            HEAD: begin
                if (bus.next_symbol_strobe) begin
                    if (cnt_q == CNT_W'(TAIL_BITS - 1)) begin
                        state_d = PAYLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.next_symbol_strobe) begin
                    sym_b = (bit_cnt_q != 4'd0) & shift_q[0];
                    if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                        state_d = TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (bus.next_symbol_strobe) begin
                    if (cnt_q == CNT_W'(TAIL_BITS - 1)) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GUARD: begin
                if (bus.next_symbol_strobe) begin
                    if (cnt_q == CNT_W'(GUARD_BITS - 1)) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        // A queued request chains straight into the next head, no idle symbol.
                        if (start_req) begin
                            state_d     = HEAD;
                            start_burst = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bytes_q    <= '0;
            prev_q     <= 1'b0;
            pending_q  <= 1'b0;
            symbol_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q <= done_d;

            if (bus.next_symbol_strobe) begin
                symbol_q <= sym_b ^ (DIFF_ENCODE & prev_q);
                prev_q   <= sym_b;
            end else if (start_burst) begin
                prev_q <= 1'b0;
            end

            if (start_burst) begin
                pending_q <= 1'b0;
            end else if ((state_q == GUARD) && bus.burst_start) begin
                pending_q <= 1'b1;
            end

            if (start_burst) begin
                underrun_q <= 1'b0;
            end else if (starve) begin
                underrun_q <= 1'b1;
            end

            // Leftover bits of the final byte simply go stale and are cleared at the next start.
            if (start_burst) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
                bytes_q   <= '0;
            end else if (accept) begin
                shift_q   <= bus.data_in;
                bit_cnt_q <= 4'd8;
                bytes_q   <= bytes_q + 1'b1;
            end else if (payload_strobe && (bit_cnt_q != 4'd0)) begin
                shift_q   <= {1'b0, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q - 4'd1;
            end
        end
    end

    assign bus.data_ready     = ready;
    assign bus.current_symbol = symbol_q;
    assign bus.burst_active   = (state_q != IDLE);
    assign bus.burst_done     = done_q;
    assign bus.underrun       = underrun_q;

endmodule
